// File: rtl/wb_writer_pkg.sv
// ============================================================================
// Module : wb_writer_pkg
// Brief  : Shared types and constants for the writeback writer slice:
//          FSM state type, beat-type tags and default widths.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_writer_pkg;

  // Writeback sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } wb_state_t;

  // Beat-type tag carried in the top payload bit
  localparam logic BEAT_ADDR = 1'b1;
  localparam logic BEAT_DATA = 1'b0;

  // Default geometry
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 16;

endpackage

`default_nettype wire

// File: rtl/wb_writer_if.sv
// ============================================================================
// Module : wb_writer_if
// Brief  : Eviction offer channel plus writeback beat channel.
//          slave  = the writer block, master = cache/memory side.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_writer_if
  import wb_writer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              evict_valid;
  logic [ADDR_W-1:0] evict_addr;
  logic [DATA_W-1:0] evict_data;
  logic              evict_ready;
  logic              dataWB_enable;
  logic [DATA_W:0]   dataWB_data;
  logic              dataWB_ack;

  modport slave (
    input  evict_valid, evict_addr, evict_data, dataWB_ack,
    output evict_ready, dataWB_enable, dataWB_data
  );

  modport master (
    output evict_valid, evict_addr, evict_data, dataWB_ack,
    input  evict_ready, dataWB_enable, dataWB_data
  );

endinterface

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// Module : wb_fifo
// Brief  : Writeback queue storage and pointers. Allocating push, head pop,
//          and an in-place data rewrite port for merging into a live entry.
//          Exposes per-slot address and liveness for the merge compare.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  wire logic                       clock,
  input  wire logic                       reset_n,
  input  wire logic                       push,
  input  wire logic [ADDR_W-1:0]          push_addr,
  input  wire logic [DATA_W-1:0]          push_data,
  input  wire logic                       pop,
  input  wire logic                       wr_en,
  input  wire logic [$clog2(DEPTH)-1:0]   wr_idx,
  input  wire logic [DATA_W-1:0]          wr_data,
  output logic      [ADDR_W-1:0]          head_addr,
  output logic      [DATA_W-1:0]          head_data,
  output logic      [ADDR_W-1:0]          next_addr,
  output logic      [$clog2(DEPTH):0]     count,
  output logic      [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic      [ADDR_W-1:0]          addr_q [DEPTH],
  output logic      [DEPTH-1:0]           live_q
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PW-1:0]     r_rd;
  logic [PW-1:0]     r_wr;
  logic [CW-1:0]     r_count;

  // Slot storage: allocate at the write pointer, merge rewrites a live slot
  always_ff @(posedge clock) begin
    if (push) begin
      r_addr[r_wr] <= push_addr;
      r_data[r_wr] <= push_data;
    end
    if (wr_en) begin
      r_data[wr_idx] <= wr_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wr <= r_wr + PW'(1);
      if (pop)  r_rd <= r_rd + PW'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below count
  always_comb begin
    live_q = '0;
    for (int i = 0; i < DEPTH; i++) begin
      live_q[i] = ({1'b0, PW'(i) - r_rd} < r_count);
    end
  end

  assign head_addr = r_addr[r_rd];
  assign head_data = r_data[r_rd];
  assign next_addr = r_addr[r_rd + PW'(1)];
  assign count     = r_count;
  assign rd_ptr    = r_rd;
  assign addr_q    = r_addr;

endmodule

`default_nettype wire

// File: rtl/wb_writer.sv
// ============================================================================
// Module : wb_writer
// Brief  : Writeback writer. Queues evicted dirty words and issues each as an
//          address beat followed by a data beat toward memory.
//          Optional macro WB_COALESCE_EN merges a push into a queued,
//          not-yet-issuing entry with the same address.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_writer
  import wb_writer_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  wire logic                   clock,
  input  wire logic                   reset_n,
  wb_writer_if.slave                  bus,
  output logic [$clog2(DEPTH):0]      wb_pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_state_t         r_state;
  logic              r_enable;
  logic [DATA_W:0]   r_payload;

  logic [ADDR_W-1:0] w_head_addr;
  logic [ADDR_W-1:0] w_next_addr;
  logic [ADDR_W-1:0] w_follow_addr;
  logic [DATA_W-1:0] w_head_data;
  logic [CW-1:0]     w_count;
  logic [PW-1:0]     w_rd_ptr;
  logic [ADDR_W-1:0] w_addr_q [DEPTH];
  logic [DEPTH-1:0]  w_live;
  logic              w_hit;
  logic [PW-1:0]     w_hit_idx;
  logic              w_full;
  logic              w_ready;
  logic              w_push;
  logic              w_alloc;
  logic              w_merge;
  logic              w_pop;
  logic              w_more;

  assign w_full  = (w_count == CW'(DEPTH));
  assign w_ready = !w_full || w_hit;
  assign w_push  = bus.evict_valid && w_ready;
  assign w_alloc = w_push && !w_hit;
  assign w_merge = w_push && w_hit;
  assign w_pop   = (r_state == ST_DATA) && bus.dataWB_ack;
  // Entries left after this pop, counting a same-edge allocation
  assign w_more  = (w_count > CW'(1)) || w_alloc;
  // With one entry left the follower is the word being pushed right now
  assign w_follow_addr = (w_count > CW'(1)) ? w_next_addr : bus.evict_addr;

`ifdef WB_COALESCE_EN
  // First live slot with a matching address; the head is off-limits once issuing
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_hit && w_live[i] && (w_addr_q[i] == bus.evict_addr) &&
          !((PW'(i) == w_rd_ptr) && (r_state != ST_IDLE))) begin
        w_hit     = 1'b1;
        w_hit_idx = PW'(i);
      end
    end
  end
`else
  logic w_unused_sink;

  assign w_hit     = 1'b0;
  assign w_hit_idx = '0;

  // Slot view only feeds the merge compare, which is absent in this build
  always_comb begin
    w_unused_sink = ^w_rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      w_unused_sink = w_unused_sink ^ (^w_addr_q[i]) ^ w_live[i];
    end
  end
`endif

  wb_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (w_alloc),
    .push_addr (bus.evict_addr),
    .push_data (bus.evict_data),
    .pop       (w_pop),
    .wr_en     (w_merge),
    .wr_idx    (w_hit_idx),
    .wr_data   (bus.evict_data),
    .head_addr (w_head_addr),
    .head_data (w_head_data),
    .next_addr (w_next_addr),
    .count     (w_count),
    .rd_ptr    (w_rd_ptr),
    .addr_q    (w_addr_q),
    .live_q    (w_live)
  );

  // Beat sequencer: address beat then data beat per entry, outputs registered
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_enable  <= 1'b0;
      r_payload <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_count != '0) begin
            r_state   <= ST_ADDR;
            r_enable  <= 1'b1;
            r_payload <= {BEAT_ADDR, DATA_W'(w_head_addr)};
          end
        end
        ST_ADDR: begin
          if (bus.dataWB_ack) begin
            r_state   <= ST_DATA;
            r_payload <= {BEAT_DATA, w_head_data};
          end
        end
        ST_DATA: begin
          if (bus.dataWB_ack) begin
            if (w_more) begin
              r_state   <= ST_ADDR;
              r_payload <= {BEAT_ADDR, DATA_W'(w_follow_addr)};
            end else begin
              r_state   <= ST_IDLE;
              r_enable  <= 1'b0;
              r_payload <= '0;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_enable  <= 1'b0;
          r_payload <= '0;
        end
      endcase
    end
  end

  assign bus.evict_ready   = w_ready;
  assign bus.dataWB_enable = r_enable;
  assign bus.dataWB_data   = r_payload;
  assign wb_pending        = w_count;

endmodule

`default_nettype wire

// File: tb/tb_wb_writer.sv
// ============================================================================
// Module : tb_wb_writer
// Brief  : Directed self-checking bench for wb_writer (DEPTH=4, ADDR_W=3,
//          DATA_W=16). Merge scenario runs only when WB_COALESCE_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_writer;

  logic       clock;
  logic       reset_n;
  logic [2:0] wb_pending;

  int n_checks = 0;
  int n_fail   = 0;

  logic [16:0] exp_q [$];

  wb_writer_if #(.ADDR_W(3), .DATA_W(16)) bus ();

  wb_writer #(
    .DEPTH  (4),
    .ADDR_W (3),
    .DATA_W (16)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .wb_pending (wb_pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; everything is driven and sampled 1ns after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_one(input logic [2:0] a, input logic [15:0] d);
    bus.evict_valid = 1'b1;
    bus.evict_addr  = a;
    bus.evict_data  = d;
    tick();
    bus.evict_valid = 1'b0;
  endtask

  // Hold ack high and expect the queued beats in order, then an idle bus
  task automatic drain(input string tag);
    bus.dataWB_ack = 1'b1;
    while (exp_q.size() != 0) begin
      logic [16:0] e;
      e = exp_q.pop_front();
      check({tag, "_en"},   32'(bus.dataWB_enable), 32'd1);
      check({tag, "_beat"}, 32'(bus.dataWB_data), 32'(e));
      tick();
    end
    check({tag, "_idle"},    32'(bus.dataWB_enable), 32'd0);
    check({tag, "_pending"}, 32'(wb_pending), 32'd0);
    bus.dataWB_ack = 1'b0;
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.evict_valid = 1'b0;
    bus.evict_addr  = '0;
    bus.evict_data  = '0;
    bus.dataWB_ack  = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_enable",  32'(bus.dataWB_enable), 32'd0);
    check("rst_data",    32'(bus.dataWB_data), 32'd0);
    check("rst_pending", 32'(wb_pending), 32'd0);
    reset_n = 1'b1;
    tick();
    check("rst_ready", 32'(bus.evict_ready), 32'd1);

    // Single entry with ack always high; ack while idle is ignored
    bus.dataWB_ack = 1'b1;
    tick();
    check("idle_ack_ignored", 32'(bus.dataWB_enable), 32'd0);
    push_one(3'd3, 16'h0012);
    check("single_pending1", 32'(wb_pending), 32'd1);
    check("single_idle",     32'(bus.dataWB_enable), 32'd0);
    tick();
    check("single_addr_en",  32'(bus.dataWB_enable), 32'd1);
    check("single_addr",     32'(bus.dataWB_data), 32'h10003);
    tick();
    check("single_data",     32'(bus.dataWB_data), 32'h00012);
    tick();
    check("single_done_en",  32'(bus.dataWB_enable), 32'd0);
    check("single_pending0", 32'(wb_pending), 32'd0);
    bus.dataWB_ack = 1'b0;

    // Fill with ack low: backpressure and stable address beat
    push_one(3'd1, 16'h1111);
    push_one(3'd2, 16'h2222);
    push_one(3'd4, 16'h4444);
    push_one(3'd7, 16'h7777);
    check("full_ready",   32'(bus.evict_ready), 32'd0);
    check("full_pending", 32'(wb_pending), 32'd4);
    tick();
    tick();
    check("stall_en",     32'(bus.dataWB_enable), 32'd1);
    check("stall_stable", 32'(bus.dataWB_data), 32'h10001);
    exp_q = '{17'h10001, 17'h01111, 17'h10002, 17'h02222,
              17'h10004, 17'h04444, 17'h10007, 17'h07777};
    drain("fifo_order");

    // Full queue, head in DATA, push and ack on the same edge
    push_one(3'd0, 16'h00A0);
    push_one(3'd1, 16'h00A1);
    push_one(3'd2, 16'h00A2);
    push_one(3'd3, 16'h00A3);
    bus.dataWB_ack = 1'b1;
    tick();
    bus.dataWB_ack = 1'b0;
    check("full_data_beat", 32'(bus.dataWB_data), 32'h000A0);
    check("full_data_pend", 32'(wb_pending), 32'd4);
    bus.evict_valid = 1'b1;
    bus.evict_addr  = 3'd5;
    bus.evict_data  = 16'h5555;
    bus.dataWB_ack  = 1'b1;
    check("full_push_refused", 32'(bus.evict_ready), 32'd0);
    tick();
    bus.evict_valid = 1'b0;
    check("full_pop_pending", 32'(wb_pending), 32'd3);
    exp_q = '{17'h10001, 17'h000A1, 17'h10002, 17'h000A2, 17'h10003, 17'h000A3};
    drain("full_rest");

    // Simultaneous push and pop keeps the count
    push_one(3'd6, 16'h0606);
    push_one(3'd7, 16'h0707);
    bus.dataWB_ack = 1'b1;
    tick();
    bus.evict_valid = 1'b1;
    bus.evict_addr  = 3'd2;
    bus.evict_data  = 16'h0202;
    tick();
    bus.evict_valid = 1'b0;
    bus.dataWB_ack  = 1'b0;
    check("pushpop_pending", 32'(wb_pending), 32'd2);
    exp_q = '{17'h10007, 17'h00707, 17'h10002, 17'h00202};
    drain("pushpop");

    // Reset while issuing a data beat with three entries queued
    push_one(3'd1, 16'hBEEF);
    push_one(3'd2, 16'hCAFE);
    push_one(3'd3, 16'hF00D);
    bus.dataWB_ack = 1'b1;
    tick();
    bus.dataWB_ack = 1'b0;
    check("prereset_beat",    32'(bus.dataWB_data), 32'h0BEEF);
    check("prereset_pending", 32'(wb_pending), 32'd3);
    reset_n = 1'b0;
    #1;
    check("reset_async_en",   32'(bus.dataWB_enable), 32'd0);
    check("reset_async_pend", 32'(wb_pending), 32'd0);
    check("reset_async_data", 32'(bus.dataWB_data), 32'd0);
    tick();
    reset_n = 1'b1;
    bus.dataWB_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("postreset_no_beat", 32'(bus.dataWB_enable), 32'd0);
    end
    check("postreset_ready", 32'(bus.evict_ready), 32'd1);
    bus.dataWB_ack = 1'b0;

`ifdef WB_COALESCE_EN
    // Merge into a waiting entry; the issuing head never merges
    push_one(3'd5, 16'h0001);
    push_one(3'd6, 16'h0002);
    check("merge_head_issuing", 32'(bus.dataWB_data), 32'h10005);
    push_one(3'd6, 16'h0068);
    check("merge_pending", 32'(wb_pending), 32'd2);
    push_one(3'd5, 16'h0096);
    check("merge_head_alloc", 32'(wb_pending), 32'd3);
    exp_q = '{17'h10005, 17'h00001, 17'h10006, 17'h00068, 17'h10005, 17'h00096};
    drain("merge");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_writer.md
WB_WRITER -- requirements
Module: wb_writer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of writeback queue entries (power of two, at least 2).
REQ-002 SHALL have parameter ADDR_W, default 3, meaning the memory word address width (8 words).
REQ-003 SHALL have parameter DATA_W, default 16, meaning the memory word width.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clock  input  1  rising-edge clock for all state.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 evict_valid  input  1  cache side offers an evicted dirty word.
REQ-007 evict_addr  input  ADDR_W  word address of the evicted word.
REQ-008 evict_data  input  DATA_W  evicted word value.
REQ-009 evict_ready  output  1  queue accepts the offer; transfer occurs when evict_valid and evict_ready are both 1 at a clock edge.
REQ-010 dataWB_enable  output  1  writeback beat valid toward memory.
REQ-011 dataWB_data  output  DATA_W+1  beat payload; bit DATA_W = beat type (1 address, 0 data).
REQ-012 dataWB_ack  input  1  memory accepts the current beat at this clock edge.
REQ-013 wb_pending  output  clog2(DEPTH)+1  number of queued entries, including the one being issued.

Function
REQ-014 evict_ready SHALL equal (wb_pending != DEPTH), independent of a same-cycle pop.
REQ-015 Accepted entries SHALL be issued in FIFO order.
REQ-016 FSM SHALL have states IDLE, ADDR, DATA.
REQ-017 IDLE: dataWB_enable=0; go to ADDR the cycle after wb_pending becomes nonzero.
REQ-018 ADDR: dataWB_enable=1, dataWB_data = {1, zeros, head addr}; hold until dataWB_ack, then go to DATA.
REQ-019 DATA: dataWB_enable=1, dataWB_data = {0, head data}; on dataWB_ack pop head, then go to ADDR if entries remain, else IDLE.
REQ-020 Payload SHALL stay stable while dataWB_enable=1 and dataWB_ack=0.
REQ-021 A push into an empty queue at edge N SHALL produce the address beat in the cycle after edge N+1 at the latest; minimum of 2 beats and 2 acked cycles per entry.
REQ-022 A simultaneous push and pop SHALL leave wb_pending unchanged.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH.
REQ-024 dataWB_ack while IDLE SHALL be ignored.

Reset
REQ-025 While reset_n=0: FSM=IDLE, queue empty, wb_pending=0, dataWB_enable=0, dataWB_data=0, evict_ready=1 once released.
REQ-026 Reset during ADDR or DATA SHALL discard all queued entries, including the partially issued one; no beat is issued after release until a new push.

Configuration
REQ-027 Macro WB_COALESCE_EN: when defined, a push whose address matches a queued, not-yet-issuing entry SHALL overwrite that entry's data without allocating (wb_pending unchanged, accepted even when full).
REQ-028 The head entry SHALL be excluded from coalescing while in ADDR or DATA.
REQ-029 When WB_COALESCE_EN is undefined, every push SHALL allocate a new entry and evict_ready follows REQ-014 only.

Structure
REQ-030 A shared package SHALL hold the FSM state type, the beat-type constants (BEAT_ADDR=1, BEAT_DATA=0) and default widths.
REQ-031 The queue storage and pointers SHALL be one sub-module, wb_fifo; the FSM and coalesce compare stay in wb_writer.

Verification
REQ-032 Single push addr=3, data=0x0012, ack always 1 -> beats 0x10003 then 0x00012, wb_pending back to 0, then IDLE.
REQ-033 Push 4 entries with ack held 0 -> evict_ready=0 after 4th push, wb_pending=4, payload 0x1xxxx stable; release ack -> 8 beats in push order.
REQ-034 Queue full with head in DATA, simultaneous push and ack -> push refused (evict_ready=0), wb_pending 4->3.
REQ-035 reset_n pulsed low during DATA with 3 entries -> dataWB_enable=0 immediately, wb_pending=0, no beats after release.
REQ-036 WB_COALESCE_EN: queue {5:0x0001 issuing, 6:0x0002}; push 6:0x0068 -> wb_pending stays 2, data beat for addr 6 is 0x00068; push 5:0x0096 allocates a new entry.
